// File: rtl/cmd_frame_parser.sv
// cmd_frame_parser
// Groups the aligned 16-bit frame stream into complete commands. Filler frames
// (Sync 0x817E, PLL-lock 0xAAAA) are dropped. A command is presented as a
// single-cycle cmd_valid strobe; the command fields hold until the next strobe.
//
// Ports:
//   clk, reset           system clock, async active-high reset
//   valid_in, datain     aligned frame stream, frame considered when valid_in=1
//   cmd_valid            one-cycle strobe, command complete
//   cmd_type             1 trig, 2 clear, 3 gpulse, 4 cal, 5 wrreg, 6 rdreg, 7 rdtrig
//   cmd_hdr, cmd_data    header frame, payload frames left-justified
//   busy                 inside a multi-frame command
//   err_count            saturating protocol error count
//   sync_count           saturating Sync frame count
//
// State table
//   state     | meaning
//   S_IDLE    | waiting for a header or trigger frame
//   S_PAYLOAD | collecting payload frames, rem_q frames still to come
module cmd_frame_parser #(
  parameter int ERR_W  = 8,
  parameter int SYNC_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [15:0]       datain,
  output logic              cmd_valid,
  output logic [2:0]        cmd_type,
  output logic [15:0]       cmd_hdr,
  output logic [47:0]       cmd_data,
  output logic              busy,
  output logic [ERR_W-1:0]  err_count,
  output logic [SYNC_W-1:0] sync_count
);

  localparam logic [15:0] SYNC_FRAME = 16'h817E;
  localparam logic [15:0] PLL_FRAME  = 16'hAAAA;

  typedef enum logic {S_IDLE, S_PAYLOAD} state_t;

  state_t             state_q, state_d;
  logic [1:0]         rem_q, rem_d;
  logic [2:0]         ptype_q, ptype_d;
  logic [15:0]        phdr_q, phdr_d;
  logic [47:0]        pay_q, pay_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic [2:0]         cmd_type_q, cmd_type_d;
  logic [15:0]        cmd_hdr_q, cmd_hdr_d;
  logic [47:0]        cmd_data_q, cmd_data_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [SYNC_W-1:0]  sync_q, sync_d;

  logic               is_sync, is_filler, err_inc;
  logic [2:0]         hdr_type;
  logic [1:0]         slot;
  logic [47:0]        pay_ins;

  function automatic logic is_trigger(input logic [7:0] b);
    case (b)
      8'h2B, 8'h2D, 8'h2E, 8'h33, 8'h35, 8'h36, 8'h39, 8'h3A,
      8'h3C, 8'h4B, 8'h4D, 8'h4E, 8'h53, 8'h55, 8'h56: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] classify(input logic [15:0] f);
    case (f)
      16'h5A5A: return 3'd2;
      16'h5C5C: return 3'd3;
      16'h6363: return 3'd4;
      16'h6666: return 3'd5;
      16'h6565: return 3'd6;
      16'h6969: return 3'd7;
      default:  return 3'd0;
    endcase
  endfunction

  function automatic logic [1:0] payload_len(input logic [2:0] t);
    case (t)
      3'd2, 3'd3: return 2'd1;
      3'd4, 3'd5: return 2'd3;
      3'd6, 3'd7: return 2'd2;
      default:    return 2'd0;
    endcase
  endfunction

  always_comb begin
    is_sync   = (datain == SYNC_FRAME);
    is_filler = is_sync || (datain == PLL_FRAME);
    hdr_type  = classify(datain);
    // Slot of the incoming payload frame: frames already received so far.
    slot      = payload_len(ptype_q) - rem_q;
    pay_ins   = pay_q;
    case (slot)
      2'd0:    pay_ins[47:32] = datain;
      2'd1:    pay_ins[31:16] = datain;
      default: pay_ins[15:0]  = datain;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    ptype_d     = ptype_q;
    phdr_d      = phdr_q;
    pay_d       = pay_q;
    cmd_valid_d = 1'b0;
    cmd_type_d  = cmd_type_q;
    cmd_hdr_d   = cmd_hdr_q;
    cmd_data_d  = cmd_data_q;
    err_inc     = 1'b0;
    sync_d      = sync_q;

    if (valid_in) begin
      if (is_sync && (sync_q != {SYNC_W{1'b1}}))
        sync_d = sync_q + {{(SYNC_W-1){1'b0}}, 1'b1};

      case (state_q)
        S_IDLE: begin
          if (is_trigger(datain[15:8])) begin
            cmd_valid_d = 1'b1;
            cmd_type_d  = 3'd1;
            cmd_hdr_d   = datain;
            cmd_data_d  = 48'd0;
          end else if (hdr_type != 3'd0) begin
            phdr_d  = datain;
            ptype_d = hdr_type;
            pay_d   = 48'd0;
            rem_d   = payload_len(hdr_type);
            state_d = S_PAYLOAD;
          end else if (!is_filler) begin
            err_inc = 1'b1;
          end
        end
        S_PAYLOAD: begin
          if (is_filler) begin
            err_inc = 1'b1;
            rem_d   = 2'd0;
            state_d = S_IDLE;
          end else begin
            pay_d = pay_ins;
            rem_d = rem_q - 2'd1;
            if (rem_q == 2'd1) begin
              cmd_valid_d = 1'b1;
              cmd_type_d  = ptype_q;
              cmd_hdr_d   = phdr_q;
              cmd_data_d  = pay_ins;
              state_d     = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    err_d = err_q;
    if (err_inc && (err_q != {ERR_W{1'b1}}))
      err_d = err_q + {{(ERR_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rem_q       <= 2'd0;
      ptype_q     <= 3'd0;
      phdr_q      <= 16'd0;
      pay_q       <= 48'd0;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= 3'd0;
      cmd_hdr_q   <= 16'd0;
      cmd_data_q  <= 48'd0;
      err_q       <= '0;
      sync_q      <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      ptype_q     <= ptype_d;
      phdr_q      <= phdr_d;
      pay_q       <= pay_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      cmd_hdr_q   <= cmd_hdr_d;
      cmd_data_q  <= cmd_data_d;
      err_q       <= err_d;
      sync_q      <= sync_d;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_type   = cmd_type_q;
  assign cmd_hdr    = cmd_hdr_q;
  assign cmd_data   = cmd_data_q;
  assign busy       = (state_q == S_PAYLOAD);
  assign err_count  = err_q;
  assign sync_count = sync_q;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Testbench for cmd_frame_parser: directed vector table, hand-written reset and
// saturation sequences, and random frames checked against a queue-based model.
module tb_cmd_frame_parser;

  localparam int ERR_W  = 8;
  localparam int SYNC_W = 8;
  localparam int SAT    = 255;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              valid_in = 1'b0;
  logic [15:0]       datain = 16'd0;
  logic              cmd_valid;
  logic [2:0]        cmd_type;
  logic [15:0]       cmd_hdr;
  logic [47:0]       cmd_data;
  logic              busy;
  logic [ERR_W-1:0]  err_count;
  logic [SYNC_W-1:0] sync_count;

  cmd_frame_parser #(.ERR_W(ERR_W), .SYNC_W(SYNC_W)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .datain(datain),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_hdr(cmd_hdr),
    .cmd_data(cmd_data), .busy(busy), .err_count(err_count),
    .sync_count(sync_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  // Reference model: a command in progress is a header plus a queue of the
  // payload frames seen so far; it completes once the queue reaches its length.
  logic [7:0]  trig_bytes [15] = '{8'h2B, 8'h2D, 8'h2E, 8'h33, 8'h35, 8'h36, 8'h39,
                                   8'h3A, 8'h3C, 8'h4B, 8'h4D, 8'h4E, 8'h53, 8'h55, 8'h56};
  logic [15:0] hdr_codes [6]  = '{16'h5A5A, 16'h5C5C, 16'h6363, 16'h6666, 16'h6565, 16'h6969};
  int          hdr_types [6]  = '{2, 3, 4, 5, 6, 7};
  int          hdr_lens  [6]  = '{1, 1, 3, 3, 2, 2};

  bit          m_in_cmd;
  logic [15:0] m_cur_hdr;
  int          m_cur_type, m_need;
  logic [15:0] m_frames[$];
  bit          m_valid;
  int          m_type, m_err, m_sync;
  logic [15:0] m_hdr;
  logic [47:0] m_data;

  function automatic bit trig_byte(input logic [7:0] b);
    foreach (trig_bytes[i]) if (trig_bytes[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int hdr_index(input logic [15:0] f);
    foreach (hdr_codes[i]) if (hdr_codes[i] == f) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_in_cmd = 0; m_frames.delete(); m_valid = 0;
    m_type = 0; m_hdr = 0; m_data = 0; m_err = 0; m_sync = 0;
  endtask

  task automatic model_step(input logic v, input logic [15:0] d);
    bit filler;
    int hi;
    m_valid = 0;
    if (v) begin
      filler = (d == 16'h817E) || (d == 16'hAAAA);
      if (d == 16'h817E) m_sync = (m_sync < SAT) ? m_sync + 1 : SAT;
      if (!m_in_cmd) begin
        hi = hdr_index(d);
        if (trig_byte(d[15:8])) begin
          m_valid = 1; m_type = 1; m_hdr = d; m_data = 0;
        end else if (hi >= 0) begin
          m_in_cmd = 1; m_cur_hdr = d; m_cur_type = hdr_types[hi];
          m_need = hdr_lens[hi]; m_frames.delete();
        end else if (!filler) begin
          m_err = (m_err < SAT) ? m_err + 1 : SAT;
        end
      end else if (filler) begin
        m_err = (m_err < SAT) ? m_err + 1 : SAT;
        m_in_cmd = 0;
      end else begin
        m_frames.push_back(d);
        if (m_frames.size() == m_need) begin
          m_valid = 1; m_type = m_cur_type; m_hdr = m_cur_hdr; m_data = 0;
          foreach (m_frames[i]) m_data = m_data | ({m_frames[i], 32'd0} >> (16 * i));
          m_in_cmd = 0;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".valid"}, 64'(cmd_valid), 64'(m_valid));
    chk({tag, ".type"},  64'(cmd_type),  64'(m_type));
    chk({tag, ".hdr"},   64'(cmd_hdr),   64'(m_hdr));
    chk({tag, ".data"},  64'(cmd_data),  64'(m_data));
    chk({tag, ".busy"},  64'(busy),      64'(m_in_cmd));
    chk({tag, ".err"},   64'(err_count), 64'(m_err));
    chk({tag, ".sync"},  64'(sync_count),64'(m_sync));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the
  // same point after the edge that captured the frame.
  task automatic step(input logic v, input logic [15:0] d, input string tag);
    valid_in = v; datain = d;
    model_step(v, d);
    @(posedge clk); #1;
    chk_model(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1; valid_in = 1'b0; datain = 16'd0;
    model_reset();
    #2;
    chk_model("reset_async");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk_model("reset_after");
  endtask

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        ev;
    logic [2:0]  et;
    logic [47:0] ed;
    logic        eb;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic v, input logic [15:0] d, input logic ev,
                     input logic [2:0] et, input logic [47:0] ed, input logic eb);
    vec_t r;
    r.v = v; r.d = d; r.ev = ev; r.et = et; r.ed = ed; r.eb = eb;
    tbl.push_back(r);
  endtask

  function automatic logic [15:0] rand_frame();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 2) return {trig_bytes[$urandom_range(0, 14)], 8'($urandom)};
    if (r <= 5) return hdr_codes[$urandom_range(0, 5)];
    if (r == 6) return 16'h817E;
    if (r == 7) return 16'hAAAA;
    return 16'($urandom);
  endfunction

  initial begin
    // WrReg with 3-cycle gaps between frames
    add(1, 16'h6666, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 16'h1234, 0, 0, 0, 1);
    add(1, 16'h6A6C, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 16'h0000, 0, 0, 0, 1);
    add(1, 16'h7172, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 16'hFFFF, 0, 0, 0, 1);
    add(1, 16'h8B8D, 1, 5, 48'h6A6C71728B8D, 0);
    add(0, 16'h0000, 0, 0, 0, 0);
    // Clear
    add(1, 16'h5A5A, 0, 0, 0, 1);
    add(1, 16'h6A6A, 1, 2, 48'h6A6A00000000, 0);
    // Cal aborted by Sync, then a trigger
    add(1, 16'h6363, 0, 0, 0, 1);
    add(1, 16'h6A6A, 0, 0, 0, 1);
    add(1, 16'h817E, 0, 0, 0, 0);
    add(1, 16'h2B01, 1, 1, 0, 0);
    // back-to-back triggers, then a header right after an emit
    add(1, 16'h4B10, 1, 1, 0, 0);
    add(1, 16'h5611, 1, 1, 0, 0);
    add(1, 16'h5C5C, 0, 0, 0, 1);
    add(1, 16'h1111, 1, 3, 48'h111100000000, 0);
    // header codes inside a payload are raw data
    add(1, 16'h6565, 0, 0, 0, 1);
    add(1, 16'h5A5A, 0, 0, 0, 1);
    add(1, 16'h6969, 1, 6, 48'h5A5A69690000, 0);
    add(1, 16'hAAAA, 0, 0, 0, 0);

    reset = 1'b1;
    #12;
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk_model("init");

    for (int i = 0; i < 20; i++) step(1, 16'h817E, "sync20");
    chk("sync20.count", 64'(sync_count), 64'd20);
    step(1, 16'h2B6A, "trig");
    chk("trig.valid", 64'(cmd_valid), 64'd1);
    chk("trig.type", 64'(cmd_type), 64'd1);
    chk("trig.hdr", 64'(cmd_hdr), 64'h2B6A);
    chk("trig.err", 64'(err_count), 64'd0);

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.valid", i), 64'(cmd_valid), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d.busy", i), 64'(busy), 64'(tbl[i].eb));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d.type", i), 64'(cmd_type), 64'(tbl[i].et));
        chk($sformatf("tbl%0d.data", i), 64'(cmd_data), 64'(tbl[i].ed));
      end
    end
    chk("tbl.err", 64'(err_count), 64'd1);
    chk("tbl.sync", 64'(sync_count), 64'd21);

    step(1, 16'h1234, "unknown");
    chk("unknown.err", 64'(err_count), 64'd2);
    for (int i = 0; i < 300; i++) step(1, 16'h1234, "unk_sat");
    chk("err_sat", 64'(err_count), 64'd255);
    for (int i = 0; i < 300; i++) step(1, 16'h817E, "sync_sat");
    chk("sync_sat", 64'(sync_count), 64'd255);

    step(1, 16'h6565, "rd_partial_h");
    step(1, 16'h6A6A, "rd_partial_p");
    do_reset();
    chk("rst.data", 64'(cmd_data), 64'd0);
    step(1, 16'h6565, "rd_h");
    step(1, 16'h6A6A, "rd_p0");
    step(1, 16'h6C6C, "rd_p1");
    chk("rd.valid", 64'(cmd_valid), 64'd1);
    chk("rd.type", 64'(cmd_type), 64'd6);
    chk("rd.data", 64'(cmd_data), 64'h6A6A6C6C0000);
    step(0, 16'h0000, "rd_idle");
    chk("rd.single", 64'(cmd_valid), 64'd0);

    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 9) < 7), rand_frame(), $sformatf("rnd%0d", i));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
